// File: rtl/lsu_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_ctrl
//  Purpose  : Load/store initiator between the core execute stage and a
//             byte-addressed 32-bit sram port. Turns RISC-V LB/LH/LW/LBU/LHU/
//             SB/SH/SW requests into sram transactions. Sub-word stores are
//             done as read-modify-write, because the sram always writes the
//             four bytes addr..addr+3. Illegal, misaligned and out-of-range
//             requests are answered with an error and never reach memory.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   clock, all state updates on posedge
//    rst          in   1   asynchronous active-low reset
//    req_valid    in   1   core request present
//    req_ready    out  1   controller can accept a request (IDLE only)
//    req_wr       in   1   1 = store, 0 = load
//    req_funct3   in   3   RISC-V funct3 width/sign code
//    req_addr     in  16   byte address
//    req_wdata    in  32   store data, low bytes significant
//    resp_valid   out  1   one-cycle response pulse
//    resp_rdata   out 32   extended load data; 0 for stores and errors
//    resp_err     out  1   request rejected; qualified by resp_valid
//    mem_enable   out  1   sram enable
//    mem_wr       out  1   sram write
//    mem_addr     out 16   sram byte address
//    mem_wdata    out 32   sram write data
//    mem_rdata    in  32   sram read data {addr+3..addr}, combinational
// ============================================================================
module lsu_mem_ctrl #(
  parameter int unsigned MEM_LIMIT        = 32'd65532,
  parameter bit          ALLOW_MISALIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_funct3,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_RMW_READ = 3'd2,
    S_WRITE    = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [15:0] addr_q, addr_d;
  logic        err_q, err_d;
  // data_q holds store data on accept, the merged word after the RMW read,
  // or the extended load result after READ; one register serves all three.
  logic [31:0] data_q, data_d;

  logic        req_fire;
  logic        req_misaligned;
  logic        req_bad_funct3;
  logic        req_out_of_range;
  logic        req_err;

  // --------------------------------------------------------------------------
  // Load data extraction and sub-word store merge
  // --------------------------------------------------------------------------
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [31:0] rd);
    logic [31:0] res;
    res = 32'd0;
    case (f3)
      F3_B:    res = {{24{rd[7]}}, rd[7:0]};
      F3_BU:   res = {24'd0, rd[7:0]};
      F3_H:    res = {{16{rd[15]}}, rd[15:0]};
      F3_HU:   res = {16'd0, rd[15:0]};
      F3_W:    res = rd;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                              input logic [31:0] old,
                                              input logic [31:0] wd);
    logic [31:0] res;
    res = old;
    case (f3)
      F3_B:    res = {old[31:8], wd[7:0]};
      F3_H:    res = {old[31:16], wd[15:0]};
      default: res = wd;
    endcase
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Request classification (only consumed at the accept edge)
  // --------------------------------------------------------------------------
  always_comb begin
    req_misaligned = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: req_misaligned = req_addr[0];
      F3_W:        req_misaligned = |req_addr[1:0];
      default:     req_misaligned = 1'b0;
    endcase
  end

  // 011/110/111 are never legal; stores have no unsigned variants.
  assign req_bad_funct3   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                            (req_funct3 == 3'b111) || (req_wr && req_funct3[2]);
  assign req_out_of_range = (32'(req_addr) >= MEM_LIMIT);
  assign req_err          = req_bad_funct3 || req_out_of_range ||
                            (!ALLOW_MISALIGNED && req_misaligned);

  // Gating with rst keeps req_ready low for the whole reset assertion even
  // though the state register already reads IDLE.
  assign req_ready = (state_q == S_IDLE) && rst;
  assign req_fire  = req_valid && req_ready;

  // --------------------------------------------------------------------------
  // State and request registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 16'd0;
      err_q    <= 1'b0;
      data_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      data_q   <= data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    err_d    = err_q;
    data_d   = data_q;

    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          wr_d     = req_wr;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          err_d    = req_err;
          // An error response must carry zero data, so drop wdata here.
          data_d   = req_err ? 32'd0 : req_wdata;
          if (req_err)                  state_d = S_RESP;
          else if (!req_wr)             state_d = S_READ;
          else if (req_funct3 == F3_W)  state_d = S_WRITE;
          else                          state_d = S_RMW_READ;
        end
      end
      S_READ: begin
        data_d  = load_extend(funct3_q, mem_rdata);
        state_d = S_RESP;
      end
      S_RMW_READ: begin
        data_d  = store_merge(funct3_q, mem_rdata, data_q);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode: purely from registered state and latched request, so the
  // asynchronous reset clears every output without waiting for a clock.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 16'd0;
    mem_wdata  = 32'd0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;

    case (state_q)
      S_READ, S_RMW_READ: begin
        mem_enable = 1'b1;
        mem_addr   = addr_q;
      end
      S_WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = addr_q;
        mem_wdata  = data_q;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        // Stores leave the merged word in data_q; it must not leak out.
        resp_rdata = (err_q || wr_q) ? 32'd0 : data_q;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that sits between the core's execute stage and the byte-addressed 32-bit sram port.
- Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into sram transactions.
- Sub-word stores become a read-modify-write, because the sram always writes 4 bytes at addr..addr+3.
- Extracts and sign/zero-extends load data, and flags illegal, misaligned or out-of-range requests without touching memory.

Parameters:
- MEM_LIMIT, 65532: first byte address rejected as out of range (accesses with addr >= MEM_LIMIT are errors).
- ALLOW_MISALIGNED, 0: when 1, misaligned LH/SH/LW/SW are accepted; when 0, they are errors.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous assert, active-low.
- req_valid  input  1  core request present.
- req_ready  output  1  controller can accept a request.
- req_wr  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 width/sign code.
- req_addr  input  16  byte address.
- req_wdata  input  32  store data, low bytes significant.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  request rejected; valid with resp_valid.
- mem_enable  output  1  to sram enable.
- mem_wr  output  1  to sram wr.
- mem_addr  output  16  to sram addr.
- mem_wdata  output  32  to sram data_in.
- mem_rdata  input  32  from sram data_out; combinational, {addr+3..addr}.

Behaviour:
- Reset (rst low):
  - state=IDLE.
  - req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - Effect is immediate, not clock-gated.
- mem_* and resp_* are decoded from registered state and latched request only. There is no combinational path from req_* to any output.
- States: IDLE, READ, RMW_READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid & req_ready) at a posedge latches wr, funct3, addr and wdata.
  - Next state after the handshake:
    - Error -> RESP.
    - Load -> READ.
    - SW -> WRITE, with merged data = req_wdata.
    - SB/SH -> RMW_READ.
- Error conditions, any of:
  - funct3 in {011, 110, 111}.
  - Store with funct3 in {100, 101}.
  - addr >= MEM_LIMIT.
  - ALLOW_MISALIGNED=0 and either halfword with addr[0]=1, or word with addr[1:0]!=0.
- On error: no mem_enable at any point, resp_err=1, resp_rdata=0.
- READ:
  - mem_enable=1, mem_wr=0, mem_addr=latched addr.
  - At the posedge, mem_rdata is captured and extended:
    - LB: sign-extend [7:0]; LBU: zero-extend [7:0].
    - LH: sign-extend [15:0]; LHU: zero-extend [15:0].
    - LW: [31:0].
  - Then -> RESP.
- RMW_READ:
  - Same memory drive as READ.
  - At the posedge, merged = mem_rdata with bytes replaced:
    - SB: [7:0] from wdata[7:0].
    - SH: [15:0] from wdata[15:0].
  - Then -> WRITE.
- WRITE:
  - mem_enable=1, mem_wr=1, mem_addr=latched addr, mem_wdata=merged.
  - The sram writes at the posedge ending this cycle.
  - Then -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, with no backpressure.
  - req_ready=0.
  - Then -> IDLE.
- Latency from the accept edge to the resp_valid cycle:
  - Error: 1 cycle.
  - Load and SW: 2 cycles.
  - SB/SH: 3 cycles.
- Throughput: one request in flight. req_ready is 0 in every non-IDLE state.
- Outside WRITE, mem_wr=0. Outside READ/RMW_READ/WRITE, mem_enable=0.
- Reset during any state aborts the request with no response.
  - Reset during WRITE drops mem_enable/mem_wr asynchronously, so no sram write occurs.
- A req_valid held high across RESP is accepted on the first IDLE edge afterwards.

Test Plan:
- SW addr=0x0100 data=0xDEADBEEF, then LW 0x0100:
  - The write occurs in the WRITE cycle with mem_wdata=0xDEADBEEF.
  - LW returns resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after accept.
- After the first test, SB addr=0x0100 data=0x00000012, then LW 0x0100:
  - RMW sequence READ-then-WRITE, with mem_wdata=0xDEADBE12.
  - LW returns 0xDEADBE12.
  - resp_valid 3 cycles after SB accept.
- Memory 0x0200..0x0203 = 80 FF 34 12:
  - LB 0x0200 -> 0xFFFFFF80.
  - LBU -> 0x00000080.
  - LH -> 0xFFFFFF80.
  - LHU -> 0x0000FF80.
  - LW -> 0x1234FF80.
- Errors, each giving resp_err=1, resp_rdata=0, mem_enable never asserted, response 1 cycle after accept:
  - LW 0x0102 (ALLOW_MISALIGNED=0).
  - LH 0xFFFD.
  - SW 0xFFFC.
  - funct3=011.
  - Store funct3=100.
- Back-to-back requests with req_valid held high:
  - req_ready deasserts after accept and re-asserts only in IDLE.
  - Exactly one resp_valid per request, in order.
- Assert rst low mid-WRITE of SW 0x0300 data=0x11111111:
  - mem_enable/mem_wr drop immediately, sram word unchanged, no resp_valid.
  - After release, req_ready=1 and the next LW 0x0300 returns the old value.
